oflow_tracker_nmr: RTL and testbench

Parametrised successor of the per-task fingerprint overflow tracker for the fingerprinting comparator subsystem. Keeps one fingerprint count and one overflow-status bit per task per logical replica core. Replica count is runtime-selectable from 2 to NUM_CORES. Overflow/underflow events go into an event FIFO and are written to processors over an Avalon-MM master. Adds over the previous generation: saturating counts, dropped-event accounting and a generalised lagging-core report.

---
 rtl/oflow_tracker_nmr_pkg.sv | 37 +++
 rtl/oflow_tracker_nmr_fifo.sv | 47 ++++
 rtl/oflow_tracker_nmr.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_oflow_tracker_nmr.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_tracker_nmr_pkg.sv
// Shared types and constants for the per-task fingerprint overflow tracker:
// FSM state encodings, event-word type codes/layout and mailbox formatting.
package oflow_tracker_nmr_pkg;

  typedef enum logic [3:0] {
    CMD_IDLE     = 4'd0,
    CMD_RST      = 4'd1,
    CMD_INC      = 4'd2,
    CMD_INC_EVAL = 4'd3,
    CMD_OF_PUSH  = 4'd4,
    CMD_DEC      = 4'd5,
    CMD_DEC_EVAL = 4'd6,
    CMD_UF_SCAN  = 4'd7,
    CMD_ACK      = 4'd8
  } cmd_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_RD   = 2'd1,
    OUT_WR   = 2'd2
  } out_state_e;

  localparam logic        EVT_OFLOW    = 1'b1;
  localparam logic        EVT_UFLOW    = 1'b0;
  localparam int          MBOX_SHIFT   = 20;
  localparam logic [31:0] WDATA_OFFSET = 32'h200;

  // Event word, LSB first: task id, physical core id, type bit.
  function automatic int evt_task_lsb(input int key_width);
    return 0 * key_width;
  endfunction

  function automatic int evt_pid_lsb(input int key_width);
    return key_width;
  endfunction

endpackage

// File: rtl/oflow_tracker_nmr_fifo.sv
// Synchronous ring-buffer FIFO holding overflow/underflow event words.
// One slot stays empty so bare pointers distinguish full from empty.
module oflow_tracker_nmr_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q + AW'(1)) == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/oflow_tracker_nmr.sv
// Per-task, per-replica fingerprint counter with overflow/underflow event
// reporting to processors through an Avalon-MM write master.
module oflow_tracker_nmr
  import oflow_tracker_nmr_pkg::*;
#(
  parameter int NUM_CORES   = 3,
  parameter int KEY_WIDTH   = 4,
  parameter int COUNT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] OFLOW_BASE = 32'h0,
  localparam int CORE_W     = $clog2(NUM_CORES + 1),
  localparam int NUM_TASKS  = 2 ** KEY_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CORE_W-1:0]      active_cores,
  input  logic [COUNT_WIDTH-1:0] maxcount,
  input  logic [KEY_WIDTH-1:0]   physical_core_id,
  input  logic                   inc_req,
  input  logic [KEY_WIDTH-1:0]   inc_task_id,
  input  logic [CORE_W-1:0]      inc_core_id,
  output logic                   inc_ack,
  input  logic                   dec_req,
  input  logic [KEY_WIDTH-1:0]   dec_task_id,
  output logic                   dec_ack,
  input  logic                   rst_task_req,
  input  logic [KEY_WIDTH-1:0]   rst_task_id,
  output logic                   rst_task_ack,
  output logic [NUM_TASKS-1:0]   fprints_ready,
  output logic [NUM_TASKS-1:0]   fprints_remaining,
  output logic [CORE_W-1:0]      lagging_core,
  output logic                   lagging_valid,
  output logic [7:0]             events_dropped,
  output logic                   av_write,
  output logic [ADDR_WIDTH-1:0]  av_address,
  output logic [DATA_WIDTH-1:0]  av_writedata,
  input  logic                   av_waitrequest
);

  localparam int EVT_W   = 2 * KEY_WIDTH + 1;
  localparam int PID_LSB = evt_pid_lsb(KEY_WIDTH);

  cmd_state_e state_q;
  out_state_e out_state_q;

  logic [KEY_WIDTH-1:0] task_q;
  logic [CORE_W-1:0]    core_q, act_q, scan_q, act_sel;
  logic [NUM_CORES-1:0][NUM_TASKS-1:0][COUNT_WIDTH-1:0] count_q;
  logic [NUM_CORES-1:0][NUM_TASKS-1:0]                  status_q;

  logic [NUM_TASKS-1:0]  ready_q, remaining_q;
  logic [CORE_W-1:0]     lag_core_q;
  logic                  lag_valid_q, inc_ack_q, dec_ack_q, rst_ack_q;
  logic [7:0]            dropped_q;
  logic                  av_write_q;
  logic [ADDR_WIDTH-1:0] av_address_q;
  logic [DATA_WIDTH-1:0] av_writedata_q;

  logic                   all_pos, any_pos, all_eq, uf_any, uf_hit, ovf;
  logic [COUNT_WIDTH-1:0] min_cnt, sel_cnt, scan_cnt;
  logic [CORE_W-1:0]      lag_core;
  logic                   sel_st, scan_st;
  logic                   push, pop, fifo_full, fifo_empty;
  logic [EVT_W-1:0]       evt_word, fifo_rdata;

  assign inc_ack           = inc_ack_q;
  assign dec_ack           = dec_ack_q;
  assign rst_task_ack      = rst_ack_q;
  assign fprints_ready     = ready_q;
  assign fprints_remaining = remaining_q;
  assign lagging_core      = lag_core_q;
  assign lagging_valid     = lag_valid_q;
  assign events_dropped    = dropped_q;
  assign av_write          = av_write_q;
  assign av_address        = av_address_q;
  assign av_writedata      = av_writedata_q;

  // Out-of-range replica counts are clamped so the excluded-core mask stays sane.
  always_comb begin
    if (active_cores < CORE_W'(2)) begin
      act_sel = CORE_W'(2);
    end else if (active_cores > CORE_W'(NUM_CORES)) begin
      act_sel = CORE_W'(NUM_CORES);
    end else begin
      act_sel = active_cores;
    end
  end

  always_comb begin
    all_pos  = 1'b1;
    any_pos  = 1'b0;
    all_eq   = 1'b1;
    uf_any   = 1'b0;
    min_cnt  = '1;
    lag_core = '0;
    sel_cnt  = '0;
    sel_st   = 1'b0;
    scan_cnt = '0;
    scan_st  = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (CORE_W'(c) < act_q) begin
        if (count_q[c][task_q] == '0) begin
          all_pos = 1'b0;
          if (status_q[c][task_q]) begin
            uf_any = 1'b1;
          end
        end else begin
          any_pos = 1'b1;
        end
        if (count_q[c][task_q] != count_q[0][task_q]) begin
          all_eq = 1'b0;
        end
        if (count_q[c][task_q] < min_cnt) begin
          min_cnt  = count_q[c][task_q];
          lag_core = CORE_W'(c);
        end
      end
      if (CORE_W'(c) == core_q) begin
        sel_cnt = count_q[c][task_q];
        sel_st  = status_q[c][task_q];
      end
      if (CORE_W'(c) == scan_q) begin
        scan_cnt = count_q[c][task_q];
        scan_st  = status_q[c][task_q];
      end
    end
  end

  assign ovf      = !sel_st && (sel_cnt >= maxcount);
  assign uf_hit   = scan_st && (scan_cnt == '0);
  assign push     = (state_q == CMD_OF_PUSH) || ((state_q == CMD_UF_SCAN) && uf_hit);
  assign evt_word = {(state_q == CMD_OF_PUSH) ? EVT_OFLOW : EVT_UFLOW, physical_core_id, task_q};
  assign pop      = (out_state_q == OUT_RD);

  // Command FSM: accepts requests, owns counters, status bits and report outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CMD_IDLE;
      task_q      <= '0;
      core_q      <= '0;
      act_q       <= '0;
      scan_q      <= '0;
      count_q     <= '0;
      status_q    <= '0;
      ready_q     <= '0;
      remaining_q <= '0;
      lag_core_q  <= '0;
      lag_valid_q <= 1'b0;
      inc_ack_q   <= 1'b0;
      dec_ack_q   <= 1'b0;
      rst_ack_q   <= 1'b0;
    end else begin
      inc_ack_q <= 1'b0;
      dec_ack_q <= 1'b0;
      rst_ack_q <= 1'b0;
      case (state_q)
        CMD_IDLE: begin
          if (rst_task_req) begin
            task_q  <= rst_task_id;
            act_q   <= act_sel;
            state_q <= CMD_RST;
          end else if (inc_req) begin
            task_q  <= inc_task_id;
            core_q  <= inc_core_id;
            act_q   <= act_sel;
            state_q <= CMD_INC;
          end else if (dec_req) begin
            task_q  <= dec_task_id;
            act_q   <= act_sel;
            state_q <= CMD_DEC;
          end else begin
            state_q <= CMD_IDLE;
          end
        end
        CMD_RST: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            count_q[c][task_q]  <= '0;
            status_q[c][task_q] <= 1'b0;
          end
          ready_q[task_q]     <= 1'b0;
          remaining_q[task_q] <= 1'b0;
          lag_valid_q         <= 1'b0;
          rst_ack_q           <= 1'b1;
          state_q             <= CMD_ACK;
        end
        CMD_INC: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            if ((CORE_W'(c) == core_q) && (count_q[c][task_q] != '1)) begin
              count_q[c][task_q] <= count_q[c][task_q] + COUNT_WIDTH'(1);
            end
          end
          state_q <= CMD_INC_EVAL;
        end
        CMD_INC_EVAL: begin
          ready_q[task_q]     <= all_pos;
          remaining_q[task_q] <= any_pos;
          lag_core_q          <= lag_core;
          lag_valid_q         <= !all_eq;
          if (ovf) begin
            state_q <= CMD_OF_PUSH;
          end else begin
            inc_ack_q <= 1'b1;
            state_q   <= CMD_ACK;
          end
        end
        CMD_OF_PUSH: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            if (CORE_W'(c) == core_q) begin
              status_q[c][task_q] <= 1'b1;
            end
          end
          inc_ack_q <= 1'b1;
          state_q   <= CMD_ACK;
        end
        CMD_DEC: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            if ((CORE_W'(c) < act_q) && (count_q[c][task_q] != '0)) begin
              count_q[c][task_q] <= count_q[c][task_q] - COUNT_WIDTH'(1);
            end
          end
          state_q <= CMD_DEC_EVAL;
        end
        CMD_DEC_EVAL: begin
          ready_q[task_q]     <= all_pos;
          remaining_q[task_q] <= any_pos;
          lag_core_q          <= lag_core;
          lag_valid_q         <= !all_eq;
          if (uf_any) begin
            scan_q  <= '0;
            state_q <= CMD_UF_SCAN;
          end else begin
            dec_ack_q <= 1'b1;
            state_q   <= CMD_ACK;
          end
        end
        CMD_UF_SCAN: begin
          for (int c = 0; c < NUM_CORES; c++) begin
            if ((CORE_W'(c) == scan_q) && uf_hit) begin
              status_q[c][task_q] <= 1'b0;
            end
          end
          if (scan_q == act_q - CORE_W'(1)) begin
            dec_ack_q <= 1'b1;
            state_q   <= CMD_ACK;
          end else begin
            scan_q <= scan_q + CORE_W'(1);
          end
        end
        CMD_ACK: begin
          state_q <= CMD_IDLE;
        end
        default: begin
          state_q <= CMD_IDLE;
        end
      endcase
    end
  end

  // A push that finds the FIFO full is lost; the status bit still moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_q <= '0;
    end else if (push && fifo_full && (dropped_q != 8'hFF)) begin
      dropped_q <= dropped_q + 8'd1;
    end
  end

  oflow_tracker_nmr_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (evt_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output FSM: pop one event, then hold the Avalon write until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state_q    <= OUT_IDLE;
      av_write_q     <= 1'b0;
      av_address_q   <= '0;
      av_writedata_q <= '0;
    end else begin
      case (out_state_q)
        OUT_IDLE: begin
          if (!fifo_empty) begin
            out_state_q <= OUT_RD;
          end else begin
            out_state_q <= OUT_IDLE;
          end
        end
        OUT_RD: begin
          av_address_q   <= OFLOW_BASE + (ADDR_WIDTH'(fifo_rdata[PID_LSB +: KEY_WIDTH]) << MBOX_SHIFT);
          av_writedata_q <= DATA_WIDTH'(WDATA_OFFSET) + DATA_WIDTH'(fifo_rdata);
          av_write_q     <= 1'b1;
          out_state_q    <= OUT_WR;
        end
        OUT_WR: begin
          if (!av_waitrequest) begin
            av_write_q  <= 1'b0;
            out_state_q <= OUT_IDLE;
          end else begin
            out_state_q <= OUT_WR;
          end
        end
        default: begin
          out_state_q <= OUT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_tracker_nmr.sv
// Self-checking bench for oflow_tracker_nmr: reference model of counts/status,
// scoreboard queue of expected Avalon writes checked by a bus monitor.
module tb_oflow_tracker_nmr;

  localparam int NC = 3;
  localparam int NT = 16;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  active_cores;
  logic [4:0]  maxcount;
  logic [3:0]  physical_core_id;
  logic        inc_req, dec_req, rst_task_req;
  logic [3:0]  inc_task_id, dec_task_id, rst_task_id;
  logic [1:0]  inc_core_id;
  logic        inc_ack, dec_ack, rst_task_ack;
  logic [15:0] fprints_ready, fprints_remaining;
  logic [1:0]  lagging_core;
  logic        lagging_valid;
  logic [7:0]  events_dropped;
  logic        av_write;
  logic [31:0] av_address, av_writedata;
  logic        av_waitrequest;

  int checks = 0;
  int errors = 0;

  int          cnt_m [NC][NT];
  int          st_m  [NC][NT];
  logic [15:0] exp_ready, exp_rem;
  logic [1:0]  exp_lag;
  logic        exp_lv;
  int          exp_drop;
  int          act_m, maxc_m;
  bit          hold_m;
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];

  oflow_tracker_nmr dut (
    .clk(clk), .reset(reset), .active_cores(active_cores), .maxcount(maxcount),
    .physical_core_id(physical_core_id),
    .inc_req(inc_req), .inc_task_id(inc_task_id), .inc_core_id(inc_core_id), .inc_ack(inc_ack),
    .dec_req(dec_req), .dec_task_id(dec_task_id), .dec_ack(dec_ack),
    .rst_task_req(rst_task_req), .rst_task_id(rst_task_id), .rst_task_ack(rst_task_ack),
    .fprints_ready(fprints_ready), .fprints_remaining(fprints_remaining),
    .lagging_core(lagging_core), .lagging_valid(lagging_valid), .events_dropped(events_dropped),
    .av_write(av_write), .av_address(av_address), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Bus monitor: every accepted write must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && av_write && !av_waitrequest) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL av_unexpected: got addr=%h data=%h, expected no write", av_address, av_writedata);
      end else begin
        logic [31:0] ea, ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (av_address !== ea || av_writedata !== ed) begin
          errors++;
          $display("FAIL av_write: got addr=%h data=%h, expected addr=%h data=%h",
                   av_address, av_writedata, ea, ed);
        end
      end
    end
  end

  function automatic void model_event(input int typ, input int t);
    logic [8:0] w;
    w = {typ[0], physical_core_id, 4'(t)};
    if (hold_m && exp_addr_q.size() >= FD) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      exp_addr_q.push_back({8'h0, physical_core_id, 20'h0});
      exp_data_q.push_back(32'h200 + {23'h0, w});
    end
  endfunction

  function automatic void model_eval(input int t);
    int mn;
    mn = 1000;
    for (int c = 0; c < act_m; c++) if (cnt_m[c][t] < mn) mn = cnt_m[c][t];
    exp_ready[t] = 1'b1;
    exp_rem[t]   = 1'b0;
    exp_lv       = 1'b0;
    exp_lag      = 2'd3;
    for (int c = 0; c < act_m; c++) begin
      if (cnt_m[c][t] == 0) exp_ready[t] = 1'b0;
      else exp_rem[t] = 1'b1;
      if (cnt_m[c][t] != mn) exp_lv = 1'b1;
      if (cnt_m[c][t] == mn && exp_lag == 2'd3) exp_lag = 2'(c);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    inc_req = 1'b0; dec_req = 1'b0; rst_task_req = 1'b0;
    for (int c = 0; c < NC; c++) for (int t = 0; t < NT; t++) begin cnt_m[c][t] = 0; st_m[c][t] = 0; end
    exp_ready = '0; exp_rem = '0; exp_lag = '0; exp_lv = 1'b0; exp_drop = 0;
    exp_addr_q.delete(); exp_data_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_addr_q.size() != 0 || av_write); i++) @(negedge clk);
  endtask

  task automatic do_inc(input int t, input int c);
    int n, exp_n;
    bit seen, ov;
    if (cnt_m[c][t] < 31) cnt_m[c][t]++;
    ov = (st_m[c][t] == 0) && (cnt_m[c][t] >= maxc_m);
    if (ov) begin st_m[c][t] = 1; model_event(1, t); end
    model_eval(t);
    exp_n = ov ? 4 : 3;
    inc_task_id = 4'(t); inc_core_id = 2'(c); inc_req = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin @(posedge clk); n++; @(negedge clk); if (inc_ack) seen = 1'b1; end
    inc_req = 1'b0;
    checks++;
    if (!seen || n != exp_n) begin
      errors++;
      $display("FAIL inc_latency t=%0d c=%0d: got %0d cycles (seen=%0d), expected %0d", t, c, n, seen, exp_n);
    end
    checks++;
    if (fprints_ready !== exp_ready || fprints_remaining !== exp_rem || lagging_core !== exp_lag ||
        lagging_valid !== exp_lv || events_dropped !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL inc_state t=%0d c=%0d: got rdy=%h rem=%h lag=%0d lv=%0d drop=%0d, expected rdy=%h rem=%h lag=%0d lv=%0d drop=%0d",
               t, c, fprints_ready, fprints_remaining, lagging_core, lagging_valid, events_dropped,
               exp_ready, exp_rem, exp_lag, exp_lv, exp_drop);
    end
    @(negedge clk);
  endtask

  task automatic do_dec(input int t);
    int n, exp_n;
    bit seen, uf;
    uf = 1'b0;
    for (int c = 0; c < act_m; c++) if (cnt_m[c][t] > 0) cnt_m[c][t]--;
    for (int c = 0; c < act_m; c++) begin
      if (st_m[c][t] != 0 && cnt_m[c][t] == 0) begin st_m[c][t] = 0; model_event(0, t); uf = 1'b1; end
    end
    model_eval(t);
    exp_n = uf ? 3 + act_m : 3;
    dec_task_id = 4'(t); dec_req = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin @(posedge clk); n++; @(negedge clk); if (dec_ack) seen = 1'b1; end
    dec_req = 1'b0;
    checks++;
    if (!seen || n != exp_n) begin
      errors++;
      $display("FAIL dec_latency t=%0d: got %0d cycles (seen=%0d), expected %0d", t, n, seen, exp_n);
    end
    checks++;
    if (fprints_ready !== exp_ready || fprints_remaining !== exp_rem || lagging_core !== exp_lag ||
        lagging_valid !== exp_lv) begin
      errors++;
      $display("FAIL dec_state t=%0d: got rdy=%h rem=%h lag=%0d lv=%0d, expected rdy=%h rem=%h lag=%0d lv=%0d",
               t, fprints_ready, fprints_remaining, lagging_core, lagging_valid,
               exp_ready, exp_rem, exp_lag, exp_lv);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({inc_ack, dec_ack, rst_task_ack, fprints_ready, fprints_remaining, lagging_core, lagging_valid,
         events_dropped, av_write, av_address, av_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%h rem=%h lag=%0d lv=%0d drop=%0d avw=%0d addr=%h data=%h, expected all 0",
               fprints_ready, fprints_remaining, lagging_core, lagging_valid, events_dropped,
               av_write, av_address, av_writedata);
    end
  endtask

  task automatic test_overflow();
    act_m = 3; active_cores = 2'd3; maxc_m = 2; maxcount = 5'd2;
    repeat (3) do_inc(5, 1);
    drain();
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL overflow_writes: %0d writes outstanding, expected 0", exp_addr_q.size());
    end
    checks++;
    if (fprints_ready[5] !== 1'b0 || lagging_core !== 2'd0 || lagging_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_report: got rdy5=%0d lag=%0d lv=%0d, expected 0 0 1", fprints_ready[5], lagging_core, lagging_valid);
    end
  endtask

  task automatic test_underflow();
    repeat (4) do_dec(5);
    drain();
    checks++;
    if (exp_addr_q.size() != 0 || fprints_remaining[5] !== 1'b0) begin
      errors++;
      $display("FAIL underflow_end: got pending=%0d rem5=%0d, expected 0 0", exp_addr_q.size(), fprints_remaining[5]);
    end
  endtask

  task automatic test_active_subset();
    act_m = 2; active_cores = 2'd2;
    do_inc(3, 0);
    do_inc(3, 1);
    do_inc(3, 2);
    checks++;
    if (fprints_ready[3] !== 1'b1) begin
      errors++; $display("FAIL subset_ready: got %0d, expected 1", fprints_ready[3]);
    end
    do_inc(7, 2);
    checks++;
    if (fprints_remaining[7] !== 1'b0) begin
      errors++; $display("FAIL subset_ignored: got rem7=%0d, expected 0", fprints_remaining[7]);
    end
    do_dec(3);
    act_m = 3; active_cores = 2'd3;
    drain();
  endtask

  task automatic test_saturation();
    maxc_m = 31; maxcount = 5'd31;
    repeat (33) do_inc(9, 0);
    do_dec(9);
    drain();
    checks++;
    if (exp_addr_q.size() != 0 || lagging_valid !== 1'b1 || lagging_core !== 2'd1) begin
      errors++;
      $display("FAIL saturation: got pending=%0d lv=%0d lag=%0d, expected 0 1 1", exp_addr_q.size(), lagging_valid, lagging_core);
    end
  endtask

  task automatic test_priority();
    int n;
    bit seen, early;
    maxc_m = 2; maxcount = 5'd2;
    for (int c = 0; c < NC; c++) begin cnt_m[c][3] = 0; st_m[c][3] = 0; end
    exp_ready[3] = 1'b0; exp_rem[3] = 1'b0; exp_lv = 1'b0;
    rst_task_id = 4'd3; rst_task_req = 1'b1;
    inc_task_id = 4'd3; inc_core_id = 2'd0; inc_req = 1'b1;
    cnt_m[0][3] = 1; model_eval(3);
    n = 0; seen = 1'b0; early = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); n++; @(negedge clk);
      if (inc_ack) early = 1'b1;
      if (rst_task_ack) seen = 1'b1;
    end
    rst_task_req = 1'b0;
    checks++;
    if (!seen || n != 2 || early) begin
      errors++; $display("FAIL priority_rst: got %0d cycles seen=%0d inc_first=%0d, expected 2 1 0", n, seen, early);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin @(posedge clk); n++; @(negedge clk); if (inc_ack) seen = 1'b1; end
    inc_req = 1'b0;
    checks++;
    if (!seen || n != 4) begin
      errors++; $display("FAIL priority_inc: got %0d cycles seen=%0d, expected 4 1", n, seen);
    end
    checks++;
    if (fprints_remaining !== exp_rem || fprints_ready !== exp_ready || lagging_core !== exp_lag) begin
      errors++;
      $display("FAIL priority_state: got rem=%h rdy=%h lag=%0d, expected rem=%h rdy=%h lag=%0d",
               fprints_remaining, fprints_ready, lagging_core, exp_rem, exp_ready, exp_lag);
    end
    @(negedge clk);
  endtask

  task automatic test_fifo_drop();
    do_reset();
    maxc_m = 1; maxcount = 5'd1;
    @(posedge clk); #1 av_waitrequest = 1'b1; hold_m = 1'b1;
    @(negedge clk);
    for (int i = 0; i < FD + 3; i++) do_inc(i % NT, i / NT);
    checks++;
    if (events_dropped !== 8'd3) begin
      errors++; $display("FAIL drop_count: got %0d, expected 3", events_dropped);
    end
    @(posedge clk); #1 av_waitrequest = 1'b0; hold_m = 1'b0;
    drain();
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++; $display("FAIL drop_writes: %0d writes outstanding, expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_reset_mid_cmd();
    bit seen;
    maxc_m = 2; maxcount = 5'd2;
    physical_core_id = 4'h6;
    do_inc(2, 0);
    drain();
    inc_task_id = 4'd4; inc_core_id = 2'd1; inc_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({inc_ack, dec_ack, rst_task_ack, fprints_ready, fprints_remaining, lagging_core, lagging_valid,
         events_dropped, av_write, av_address, av_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%h rem=%h lag=%0d lv=%0d drop=%0d addr=%h data=%h, expected all 0",
               fprints_ready, fprints_remaining, lagging_core, lagging_valid, events_dropped, av_address, av_writedata);
    end
    inc_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NC; c++) for (int t = 0; t < NT; t++) begin cnt_m[c][t] = 0; st_m[c][t] = 0; end
    exp_ready = '0; exp_rem = '0; exp_lag = '0; exp_lv = 1'b0; exp_drop = 0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (inc_ack) seen = 1'b1; end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_mid_ack: got ack after reset, expected none");
    end
    do_inc(4, 1);
  endtask

  initial begin
    reset = 1'b1;
    active_cores = 2'd3; maxcount = 5'd2; physical_core_id = 4'hA;
    inc_req = 1'b0; dec_req = 1'b0; rst_task_req = 1'b0;
    inc_task_id = 4'd0; inc_core_id = 2'd0; dec_task_id = 4'd0; rst_task_id = 4'd0;
    av_waitrequest = 1'b0;
    act_m = 3; maxc_m = 2; hold_m = 1'b0;
    test_reset();
    test_overflow();
    test_underflow();
    test_active_subset();
    test_saturation();
    test_priority();
    test_fifo_drop();
    test_reset_mid_cmd();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
